// File: rtl/present_sbox_sched.sv
// Time-shares one external PRESENT S-box between a full-state sBoxLayer pass
// (one nibble per cycle) and single-nibble key-schedule substitutions.
module present_sbox_sched #(
   parameter int NIBBLES = 16,
   parameter int IDXW    = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 st_valid,
   output logic                 st_ready,
   input  logic [4*NIBBLES-1:0] st_in,
   output logic [4*NIBBLES-1:0] st_out,
   output logic                 st_done,
   input  logic                 key_valid,
   output logic                 key_ready,
   input  logic [3:0]           key_nib_in,
   output logic [3:0]           key_nib_out,
   output logic                 key_done,
   output logic [3:0]           sbox_x,
   input  logic [3:0]           sbox_r
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t                 state_r, state_s;
   logic [IDXW-1:0]        idx_r, idx_s;
   logic [4*NIBBLES-1:0]   buf_r, buf_s;
   logic                   cooldown_r, cooldown_s;
   logic [4*NIBBLES-1:0]   st_out_r, st_out_s;
   logic                   st_done_r, st_done_s;
   logic [3:0]             key_nib_out_r, key_nib_out_s;
   logic                   key_done_r, key_done_s;

   logic                   key_ready_s;
   logic                   key_gnt_s;
   logic                   last_s;
   logic [3:0]             cur_nib_s;
   logic [4*NIBBLES-1:0]   stepped_s;
   logic [3:0]             sbox_x_s;

   // Replace nibble i of a state word with n.
   function automatic logic [4*NIBBLES-1:0] put_nib(
      input logic [4*NIBBLES-1:0] w,
      input logic [IDXW-1:0]      i,
      input logic [3:0]           n
   );
      logic [4*NIBBLES-1:0] o;
      o = w;
      o[{i, 2'b00} +: 4] = n;
      return o;
   endfunction

   // The key side is held off for one cycle after each grant taken during a
   // layer pass, which guarantees the layer forward progress.
   assign key_ready_s = ~cooldown_r;
   assign key_gnt_s   = key_valid & key_ready_s;
   assign last_s      = (idx_r == IDXW'(NIBBLES - 1));
   assign cur_nib_s   = buf_r[{idx_r, 2'b00} +: 4];
   assign stepped_s   = put_nib(buf_r, idx_r, sbox_r);

   // S-box input mux: key grant wins, then the layer nibble, else zero.
   always_comb begin
      sbox_x_s = 4'h0;
      if (key_gnt_s) begin
         sbox_x_s = key_nib_in;
      end else if (state_r == RUN) begin
         sbox_x_s = cur_nib_s;
      end else begin
         sbox_x_s = 4'h0;
      end
   end

   // Next-state logic for the layer FSM, key service and result registers.
   always_comb begin
      state_s       = state_r;
      idx_s         = idx_r;
      buf_s         = buf_r;
      cooldown_s    = 1'b0;
      st_out_s      = st_out_r;
      st_done_s     = 1'b0;
      key_nib_out_s = key_nib_out_r;
      key_done_s    = 1'b0;

      if (key_gnt_s) begin
         key_nib_out_s = sbox_r;
         key_done_s    = 1'b1;
      end else begin
         key_done_s    = 1'b0;
      end

      case (state_r)
         IDLE: begin
            if (st_valid) begin
               buf_s   = st_in;
               idx_s   = '0;
               state_s = RUN;
            end else begin
               state_s = IDLE;
            end
         end
         RUN: begin
            if (key_gnt_s) begin
               cooldown_s = 1'b1;
            end else begin
               buf_s = stepped_s;
               if (last_s) begin
                  st_out_s  = stepped_s;
                  st_done_s = 1'b1;
                  idx_s     = '0;
                  state_s   = IDLE;
               end else begin
                  idx_s = idx_r + IDXW'(1);
               end
            end
         end
         default: begin
            state_s = IDLE;
            idx_s   = '0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         idx_r         <= '0;
         buf_r         <= '0;
         cooldown_r    <= 1'b0;
         st_out_r      <= '0;
         st_done_r     <= 1'b0;
         key_nib_out_r <= 4'h0;
         key_done_r    <= 1'b0;
      end else begin
         state_r       <= state_s;
         idx_r         <= idx_s;
         buf_r         <= buf_s;
         cooldown_r    <= cooldown_s;
         st_out_r      <= st_out_s;
         st_done_r     <= st_done_s;
         key_nib_out_r <= key_nib_out_s;
         key_done_r    <= key_done_s;
      end
   end

   assign st_ready    = (state_r == IDLE);
   assign key_ready   = key_ready_s;
   assign st_out      = st_out_r;
   assign st_done     = st_done_r;
   assign key_nib_out = key_nib_out_r;
   assign key_done    = key_done_r;
   assign sbox_x      = sbox_x_s;

endmodule

// File: tb/tb_present_sbox_sched.sv
// Randomised and directed bench for present_sbox_sched with an external S-box
// model and a transaction-level reference of the expected results.
module tb_present_sbox_sched;
   localparam int NIB = 16;
   localparam logic [3:0] SBOX [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          st_valid = 1'b0;
   logic          st_ready;
   logic [63:0]   st_in = 64'h0;
   logic [63:0]   st_out;
   logic          st_done;
   logic          key_valid = 1'b0;
   logic          key_ready;
   logic [3:0]    key_nib_in = 4'h0;
   logic [3:0]    key_nib_out;
   logic          key_done;
   logic [3:0]    sbox_x;
   logic [3:0]    sbox_r;

   int n_run  = 0;
   int n_fail = 0;
   logic [63:0] last_out = 64'h0;
   logic [3:0]  last_key = 4'h0;

   always #5 clk = ~clk;
   assign sbox_r = SBOX[sbox_x];

   present_sbox_sched #(.NIBBLES(NIB), .IDXW(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .st_valid(st_valid), .st_ready(st_ready), .st_in(st_in),
      .st_out(st_out), .st_done(st_done),
      .key_valid(key_valid), .key_ready(key_ready), .key_nib_in(key_nib_in),
      .key_nib_out(key_nib_out), .key_done(key_done),
      .sbox_x(sbox_x), .sbox_r(sbox_r)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] layer_ref(input logic [63:0] d);
      logic [63:0] r;
      for (int i = 0; i < NIB; i++) r[4*i +: 4] = SBOX[d[4*i +: 4]];
      return r;
   endfunction

   // mode: 0 no key traffic, 1 key_valid held with nibble fkn, 2 random traffic.
   task automatic layer_txn(input logic [63:0] din, input int mode, input logic [3:0] fkn,
                            input bit simul, input logic [3:0] skn);
      int steps = 0;
      int grants = 0;
      int edges = 0;
      bit cool = 1'b0;
      bit pend;
      bit kv;
      logic [3:0] pk;
      logic [63:0] exp_out;
      exp_out = layer_ref(din);
      @(negedge clk);
      chk("st_ready_idle", st_ready, 1'b1);
      st_valid = 1'b1; st_in = din; key_valid = simul; key_nib_in = skn;
      pend = simul; pk = skn;
      @(posedge clk);
      forever begin
         @(negedge clk);
         st_valid = 1'b0;
         st_in = {$urandom, $urandom};
         chk("key_done", key_done, pend);
         if (pend) last_key = SBOX[pk];
         chk("key_nib_out", key_nib_out, last_key);
         if (steps == NIB) begin
            chk("st_done", st_done, 1'b1);
            chk("st_out", st_out, exp_out);
            chk("st_ready_at_done", st_ready, 1'b1);
            chk("latency", edges, NIB + grants);
            last_out = exp_out;
            key_valid = 1'b0;
            break;
         end
         if (edges >= 2*NIB + 4) begin
            chk("timeout_st_done", st_done, 1'b1);
            key_valid = 1'b0;
            break;
         end
         chk("st_done_low", st_done, 1'b0);
         chk("st_ready_run", st_ready, 1'b0);
         chk("st_out_hold", st_out, last_out);
         chk("key_ready", key_ready, !cool);
         kv = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
         key_valid = kv;
         key_nib_in = (mode == 1) ? fkn : 4'($urandom);
         #1;
         if (kv && !cool) begin
            chk("sbox_x_key", sbox_x, key_nib_in);
            pend = 1'b1; pk = key_nib_in; cool = 1'b1; grants++;
         end else begin
            chk("sbox_x_layer", sbox_x, din[4*steps +: 4]);
            pend = 1'b0; cool = 1'b0; steps++;
         end
         edges++;
      end
   endtask

   // Consecutive key grants in IDLE; each result appears one edge later.
   task automatic key_burst(input int n, input logic [3:0] v0, input logic [3:0] v1,
                            input logic [3:0] v2, input bit rnd);
      logic [3:0] vals [3];
      logic [3:0] sent;
      vals = '{v0, v1, v2};
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (i > 0) begin
            chk("burst_key_done", key_done, 1'b1);
            chk("burst_key_out", key_nib_out, SBOX[sent]);
            last_key = SBOX[sent];
         end
         chk("burst_key_ready", key_ready, 1'b1);
         chk("burst_st_ready", st_ready, 1'b1);
         if (i < n) begin
            sent = rnd ? 4'($urandom) : vals[i % 3];
            key_valid = 1'b1; key_nib_in = sent;
            #1 chk("burst_sbox_x", sbox_x, sent);
         end else begin
            key_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("burst_key_done_clr", key_done, 1'b0);
      chk("burst_key_hold", key_nib_out, last_key);
   endtask

   initial begin
      logic [63:0] d;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_st_out", st_out, 64'h0);
      chk("rst_st_done", st_done, 1'b0);
      chk("rst_key_out", key_nib_out, 4'h0);
      chk("rst_key_done", key_done, 1'b0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_st_ready", st_ready, 1'b1);
      chk("idle_key_ready", key_ready, 1'b1);
      chk("idle_sbox_x", sbox_x, 4'h0);

      layer_txn(64'h0, 0, 4'h0, 1'b0, 4'h0);
      chk("zero_layer", st_out, 64'hCCCCCCCCCCCCCCCC);
      layer_txn(64'h0123456789ABCDEF, 0, 4'h0, 1'b0, 4'h0);
      chk("ramp_layer", st_out, 64'hC56B90AD3EF84712);
      @(negedge clk);
      chk("st_done_one_cycle", st_done, 1'b0);
      key_burst(3, 4'h5, 4'hA, 4'hF, 1'b0);
      layer_txn(64'h0123456789ABCDEF, 1, 4'h3, 1'b0, 4'h0);
      chk("held_key_out", key_nib_out, 4'hB);
      layer_txn(64'hFFFFFFFFFFFFFFFF, 0, 4'h0, 1'b1, 4'h0);
      chk("simul_layer", st_out, 64'h2222222222222222);

      for (int t = 0; t < 8; t++) begin
         d = {$urandom, $urandom};
         layer_txn(d, 2, 4'h0, 1'($urandom_range(0, 1)), 4'($urandom));
      end
      key_burst(5, 4'h0, 4'h0, 4'h0, 1'b1);

      // Asynchronous reset in the middle of a pass.
      @(negedge clk);
      st_valid = 1'b1; st_in = {$urandom, $urandom};
      @(negedge clk);
      st_valid = 1'b0;
      repeat (7) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_st_out", st_out, 64'h0);
      chk("mid_rst_st_done", st_done, 1'b0);
      chk("mid_rst_key_out", key_nib_out, 4'h0);
      chk("mid_rst_st_ready", st_ready, 1'b1);
      chk("mid_rst_sbox_x", sbox_x, 4'h0);
      last_out = 64'h0; last_key = 4'h0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("no_done_after_rst", st_done, 1'b0);
         if (i == 2) rst_n = 1'b1;
      end
      chk("st_out_stays_zero", st_out, 64'h0);
      layer_txn(64'hDEADBEEF01234567, 0, 4'h0, 1'b0, 4'h0);
      layer_txn({$urandom, $urandom}, 2, 4'h0, 1'b0, 4'h0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
